// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART transmit buffer slice.
package uart_pkg;

  localparam int BYTE_W              = 8;
  localparam int DEFAULT_TIMEOUT_CYC = 200000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Producer / uart_sender facing signals of the transmit buffer.
// The master side drives writes and sender status; the slave side is the buffer.
interface uart_tx_buffer_if #(
  parameter int ADDR_W = 4
);

  logic                       wr_en;
  logic [uart_pkg::BYTE_W-1:0] wr_data;
  logic                       clr_err;
  logic                       full;
  logic                       empty;
  logic [ADDR_W:0]            count;
  logic                       send_en;
  logic [uart_pkg::BYTE_W-1:0] data;
  logic                       tx_done;
  logic                       uart_state;
  logic                       overflow;
  logic                       timeout;

  modport master (
    output wr_en, wr_data, clr_err, tx_done, uart_state,
    input  full, empty, count, send_en, data, overflow, timeout
  );

  modport slave (
    input  wr_en, wr_data, clr_err, tx_done, uart_state,
    output full, empty, count, send_en, data, overflow, timeout
  );

endinterface

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Circular byte FIFO with combinational read-at-head; rd_data is valid while !empty.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [ADDR_W:0]  count
);

  localparam int CW = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus scheduler feeding uart_sender one byte at a time,
// with a watchdog that abandons a byte if tx_done never arrives.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int GAP_CYC     = 2
) (
  input logic             clk,
  input logic             rst,
  uart_tx_buffer_if.slave bus
);

  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  tx_state_t         state;
  logic [WD_W-1:0]   wd_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [BYTE_W-1:0] head_byte;
  logic [BYTE_W-1:0] data_q;
  logic              send_en_q;
  logic              overflow_q;
  logic              timeout_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              issue;
  logic              wd_expire;
  logic              drop;

  assign issue     = (state == S_IDLE) && !fifo_empty && !bus.uart_state;
  assign wd_expire = (state == S_WAIT) && !bus.tx_done
                     && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign drop      = bus.wr_en && fifo_full;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (issue),
    .rd_data (head_byte),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (bus.count)
  );

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.send_en  = send_en_q;
  assign bus.data     = data_q;
  assign bus.overflow = overflow_q;
  assign bus.timeout  = timeout_q;

  // A timed-out byte is dropped, not retried; both exits from WAIT pass through GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      send_en_q <= 1'b0;
      data_q    <= '0;
      wd_cnt    <= '0;
      gap_cnt   <= '0;
    end else begin
      send_en_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue) begin
            data_q    <= head_byte;
            send_en_q <= 1'b1;
            wd_cnt    <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.tx_done || wd_expire) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYC - 1)) state <= S_IDLE;
          else                                gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Set events take priority over clr_err so no error is lost on the clearing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (drop)             overflow_q <= 1'b1;
      else if (bus.clr_err) overflow_q <= 1'b0;
      if (wd_expire)        timeout_q  <= 1'b1;
      else if (bus.clr_err) timeout_q  <= 1'b0;
    end
  end

endmodule
